ofdm_rx_ctrl: RTL and testbench
===============================

// Module: ofdm_rx_ctrl
// PURPOSE
//  Run-time sequencer for the OFDM RX datapath. Drives its sys_init and min_level inputs,
//  watches the sample strobe and the demapped-data strobes, counts symbols per frame and
//  re-initialises the datapath on sync loss. Sits beside the RX core in the RX top level,
//  between the system/bench control and the core's configuration inputs.
// PARAMETERS
//  LEVEL_WIDTH_G        16     width of min_level / level_cfg
//  INIT_CYCLES_G        16     cycles sys_init is held high in INIT (>=1)
//  BEATS_PER_SYMBOL_G   128    rx_rcv_data_valid beats per OFDM symbol (>=2)
//  SYMBOLS_PER_FRAME_G  10     symbols per frame (>=1)
//  SEARCH_TIMEOUT_G     8000   max rx_data_valid samples in SEARCH before sync loss
//  GAP_TIMEOUT_G        640    max rx_data_valid samples between beats in RECEIVE
// PORTS
//  sys_clk            in   1            system clock
//  sys_rst            in   1            asynchronous reset, active high
//  start              in   1            pulse: leave IDLE and begin acquisition
//  stop               in   1            level/pulse: abort to IDLE (priority over start)
//  continuous         in   1            1: after frame return to SEARCH; 0: return to IDLE
//  level_cfg          in   LEVEL_WIDTH_G coarse-alignment level, sampled on leaving IDLE
//  rx_data_valid      in   1            RX sample strobe (timeout time base)
//  rx_rcv_data_valid  in   1            demapped data beat valid
//  rx_rcv_data_start  in   1            first beat of a symbol (only meaningful with valid)
//  sys_init           out  1            datapath init/clear, high in IDLE and INIT
//  min_level          out  LEVEL_WIDTH_G registered level to datapath
//  busy               out  1            high in INIT/SEARCH/RECEIVE
//  frame_done         out  1            1-cycle pulse on last beat of last symbol
//  sync_lost          out  1            1-cycle pulse on any timeout
//  symbol_cnt         out  8            symbols completed in current frame
//  err_cnt            out  8            saturating count of misaligned starts, clears on start
// BEHAVIOUR
//  Reset: state IDLE, sys_init=1, min_level=0, busy=0, frame_done=0, sync_lost=0,
//   symbol_cnt=0, err_cnt=0, all internal counters 0. All outputs registered.
//  IDLE: sys_init=1. start & !stop -> INIT next cycle; level_cfg latched into min_level,
//   err_cnt cleared on the same edge.
//  INIT: sys_init=1 for exactly INIT_CYCLES_G cycles, then SEARCH (sys_init=0 from then on).
//  SEARCH: sample counter counts rx_data_valid. rx_rcv_data_valid & rx_rcv_data_start ->
//   RECEIVE, that beat counts as beat 1 of symbol 1. Counter reaching SEARCH_TIMEOUT_G ->
//   sync_lost pulse, INIT. Valid beats without start are ignored.
//  RECEIVE: beat counter 1..BEATS_PER_SYMBOL_G on each valid beat; on beat
//   BEATS_PER_SYMBOL_G symbol_cnt+1, beat counter wraps to 0. Gap counter counts
//   rx_data_valid, clears on every valid beat; reaching GAP_TIMEOUT_G -> sync_lost, INIT.
//  Misaligned start (start with beat counter !=0 in RECEIVE): err_cnt+1 (saturates at 255),
//   beat counter restarts at 1; the partial symbol is not counted.
//  Frame end: beat BEATS_PER_SYMBOL_G of symbol SYMBOLS_PER_FRAME_G -> frame_done pulse,
//   symbol_cnt=0 next cycle; continuous=1 -> SEARCH (counters cleared), else IDLE.
//  Simultaneous: stop beats everything (-> IDLE next cycle, no pulses issued); timeout and
//   valid beat on same cycle -> beat wins, gap counter clears; last beat and misaligned
//   start on same cycle -> treated as misaligned (no frame_done).
//  start outside IDLE is ignored. Reset mid-frame -> immediate reset values, no pulses.
//  symbol_cnt is cleared on every entry to INIT.
// TESTING
//  1 reset, start, level_cfg=11000 -> min_level=11000, sys_init high 16 cycles then low.
//  2 start beat + 1279 beats more (10x128) -> symbol_cnt steps 1..9, frame_done once, IDLE.
//  3 continuous=1, two back-to-back frames -> 2 frame_done pulses, state SEARCH, busy=1.
//  4 no start for 8000 rx_data_valid in SEARCH -> sync_lost pulse, 16-cycle sys_init again.
//  5 stall beats 640 samples mid-symbol 3 -> sync_lost, INIT, symbol_cnt=0.
//  6 start at beat 50 of symbol 2 -> err_cnt=1, frame needs 10 full symbols; stop -> IDLE.

Source files
------------

// File: rtl/ofdm_rx_ctrl.sv
// ofdm_rx_ctrl: run-time sequencer for the OFDM RX datapath (init, sync search, symbol/frame counting, sync-loss recovery)
module ofdm_rx_ctrl #(
  parameter int LEVEL_WIDTH_G       = 16,
  parameter int INIT_CYCLES_G       = 16,
  parameter int BEATS_PER_SYMBOL_G  = 128,
  parameter int SYMBOLS_PER_FRAME_G = 10,
  parameter int SEARCH_TIMEOUT_G    = 8000,
  parameter int GAP_TIMEOUT_G       = 640
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     continuous,
  input  logic [LEVEL_WIDTH_G-1:0] level_cfg,
  input  logic                     rx_data_valid,
  input  logic                     rx_rcv_data_valid,
  input  logic                     rx_rcv_data_start,
  output logic                     sys_init,
  output logic [LEVEL_WIDTH_G-1:0] min_level,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     sync_lost,
  output logic [7:0]               symbol_cnt,
  output logic [7:0]               err_cnt
);
  localparam int IW = $clog2(INIT_CYCLES_G + 1);
  localparam int BW = $clog2(BEATS_PER_SYMBOL_G + 1);
  localparam int TW = $clog2(((SEARCH_TIMEOUT_G > GAP_TIMEOUT_G) ? SEARCH_TIMEOUT_G : GAP_TIMEOUT_G) + 1);
  localparam logic [IW-1:0] INIT_LAST   = IW'(INIT_CYCLES_G - 1);
  localparam logic [BW-1:0] BEAT_LAST   = BW'(BEATS_PER_SYMBOL_G - 1);
  localparam logic [7:0]    SYM_LAST    = 8'(SYMBOLS_PER_FRAME_G - 1);
  localparam logic [TW-1:0] SEARCH_LAST = TW'(SEARCH_TIMEOUT_G - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_TIMEOUT_G - 1);

  typedef enum logic [1:0] {IDLE, INIT, SEARCH, RECEIVE} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            init_cnt_q, init_cnt_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic [7:0]               symbol_cnt_q, symbol_cnt_d;
  logic [7:0]               err_cnt_q, err_cnt_d;
  logic [LEVEL_WIDTH_G-1:0] min_level_q, min_level_d;
  logic                     frame_done_q, frame_done_d;
  logic                     sync_lost_q, sync_lost_d;
  logic                     sys_init_q, busy_q;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    timer_d      = timer_q;
    beat_d       = beat_q;
    symbol_cnt_d = symbol_cnt_q;
    err_cnt_d    = err_cnt_q;
    min_level_d  = min_level_q;
    frame_done_d = 1'b0;
    sync_lost_d  = 1'b0;
    if (stop) begin
      state_d    = IDLE;
      init_cnt_d = '0;
      timer_d    = '0;
      beat_d     = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d      = INIT;
          min_level_d  = level_cfg;
          err_cnt_d    = '0;
          init_cnt_d   = '0;
          symbol_cnt_d = '0;
        end
        INIT: if (init_cnt_q == INIT_LAST) begin
          state_d    = SEARCH;
          init_cnt_d = '0;
          timer_d    = '0;
          beat_d     = '0;
        end else init_cnt_d = init_cnt_q + 1'b1;
        SEARCH: if (rx_rcv_data_valid && rx_rcv_data_start) begin
          state_d = RECEIVE;
          beat_d  = BW'(1);
          timer_d = '0;
        end else if (rx_data_valid) begin
          if (timer_q == SEARCH_LAST) begin
            state_d      = INIT;
            sync_lost_d  = 1'b1;
            timer_d      = '0;
            symbol_cnt_d = '0;
          end else timer_d = timer_q + 1'b1;
        end
        RECEIVE: if (rx_rcv_data_valid) begin
          // A valid beat always clears the gap timer, even on the cycle it would expire
          timer_d = '0;
          if (rx_rcv_data_start && beat_q != '0) begin
            beat_d    = BW'(1);
            err_cnt_d = err_cnt_q + {7'd0, err_cnt_q != 8'hff};
          end else if (beat_q == BEAT_LAST) begin
            beat_d = '0;
            if (symbol_cnt_q == SYM_LAST) begin
              frame_done_d = 1'b1;
              symbol_cnt_d = '0;
              state_d      = continuous ? SEARCH : IDLE;
            end else symbol_cnt_d = symbol_cnt_q + 1'b1;
          end else beat_d = beat_q + 1'b1;
        end else if (rx_data_valid) begin
          if (timer_q == GAP_LAST) begin
            state_d      = INIT;
            sync_lost_d  = 1'b1;
            timer_d      = '0;
            beat_d       = '0;
            symbol_cnt_d = '0;
          end else timer_d = timer_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      init_cnt_q   <= '0;
      timer_q      <= '0;
      beat_q       <= '0;
      symbol_cnt_q <= '0;
      err_cnt_q    <= '0;
      min_level_q  <= '0;
      frame_done_q <= 1'b0;
      sync_lost_q  <= 1'b0;
      sys_init_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      timer_q      <= timer_d;
      beat_q       <= beat_d;
      symbol_cnt_q <= symbol_cnt_d;
      err_cnt_q    <= err_cnt_d;
      min_level_q  <= min_level_d;
      frame_done_q <= frame_done_d;
      sync_lost_q  <= sync_lost_d;
      sys_init_q   <= (state_d == IDLE) || (state_d == INIT);
      busy_q       <= state_d != IDLE;
    end
  end

  assign sys_init   = sys_init_q;
  assign min_level  = min_level_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign sync_lost  = sync_lost_q;
  assign symbol_cnt = symbol_cnt_q;
  assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_ofdm_rx_ctrl.sv
// tb_ofdm_rx_ctrl: directed self-checking bench for ofdm_rx_ctrl with default parameters
module tb_ofdm_rx_ctrl;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [15:0] level_cfg = '0;
  logic        rx_data_valid = 1'b0, rx_rcv_data_valid = 1'b0, rx_rcv_data_start = 1'b0;
  logic        sys_init, busy, frame_done, sync_lost;
  logic [15:0] min_level;
  logic [7:0]  symbol_cnt, err_cnt;
  int          n_chk = 0, n_fail = 0, fd_cnt = 0, sl_cnt = 0;

  ofdm_rx_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop), .continuous(continuous),
    .level_cfg(level_cfg), .rx_data_valid(rx_data_valid), .rx_rcv_data_valid(rx_rcv_data_valid),
    .rx_rcv_data_start(rx_rcv_data_start), .sys_init(sys_init), .min_level(min_level), .busy(busy),
    .frame_done(frame_done), .sync_lost(sync_lost), .symbol_cnt(symbol_cnt), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    fd_cnt <= fd_cnt + int'(frame_done);
    sl_cnt <= sl_cnt + int'(sync_lost);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic beat(input logic st, input logic dv);
    rx_rcv_data_valid = 1'b1;
    rx_rcv_data_start = st;
    rx_data_valid     = dv;
    tick();
    rx_rcv_data_valid = 1'b0;
    rx_rcv_data_start = 1'b0;
    rx_data_valid     = 1'b0;
  endtask

  task automatic beats(input int n, input logic first_st);
    for (int i = 0; i < n; i++) beat(first_st && i == 0, 1'b0);
  endtask

  task automatic start_acq();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic count_init(input string tag);
    int n = 0;
    while (sys_init && n < 100) begin
      n++;
      tick();
    end
    check(tag, n, 16);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_sys_init", sys_init, 1);
    check("rst_min_level", min_level, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {frame_done, sync_lost}, 0);
    check("rst_symbol_cnt", symbol_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    sys_rst = 1'b0;
    tick();
    check("idle_sys_init", sys_init, 1);

    level_cfg = 16'd11000;
    start_acq();
    level_cfg = 16'd0;
    check("t1_min_level", min_level, 11000);
    check("t1_busy", busy, 1);
    count_init("t1_init_len");
    check("t1_search_busy", busy, 1);

    for (int i = 1; i <= 1280; i++) begin
      beat(i == 1, 1'b0);
      if (i % 128 == 0 && i < 1280) check("t2_symbol_cnt", symbol_cnt, i / 128);
    end
    check("t2_frame_done", frame_done, 1);
    check("t2_symbol_clr", symbol_cnt, 0);
    check("t2_idle_busy", busy, 0);
    check("t2_idle_init", sys_init, 1);
    tick();
    check("t2_fd_pulse", frame_done, 0);
    check("t2_fd_count", fd_cnt, 1);
    check("t2_min_level_hold", min_level, 11000);

    continuous = 1'b1;
    start_acq();
    repeat (16) tick();
    check("t3_search", sys_init, 0);
    beats(1280, 1'b1);
    beats(1280, 1'b1);
    tick();
    check("t3_fd_count", fd_cnt, 3);
    check("t3_busy", busy, 1);
    check("t3_sys_init", sys_init, 0);

    rx_data_valid = 1'b1;
    repeat (7999) tick();
    check("t4_no_loss", sync_lost, 0);
    tick();
    rx_data_valid = 1'b0;
    check("t4_sync_lost", sync_lost, 1);
    check("t4_busy", busy, 1);
    count_init("t4_init_len");
    check("t4_sl_count", sl_cnt, 1);

    beats(306, 1'b1);
    check("t5_symbol_cnt", symbol_cnt, 2);
    rx_data_valid = 1'b1;
    repeat (639) tick();
    beat(1'b0, 1'b1);
    check("t5_beat_wins", sync_lost, 0);
    rx_data_valid = 1'b1;
    repeat (639) tick();
    check("t5_no_loss", sync_lost, 0);
    check("t5_symbol_hold", symbol_cnt, 2);
    tick();
    rx_data_valid = 1'b0;
    check("t5_sync_lost", sync_lost, 1);
    check("t5_symbol_clr", symbol_cnt, 0);
    check("t5_sys_init", sys_init, 1);
    repeat (16) tick();
    check("t5_search", sys_init, 0);

    beats(177, 1'b1);
    beat(1'b1, 1'b0);
    check("t6_err_cnt", err_cnt, 1);
    check("t6_symbol_cnt", symbol_cnt, 1);
    beats(127, 1'b0);
    check("t6_symbol_2", symbol_cnt, 2);
    beats(8 * 128 - 1, 1'b0);
    check("t6_symbol_9", symbol_cnt, 9);
    check("t6_no_fd", frame_done, 0);
    beat(1'b0, 1'b0);
    check("t6_frame_done", frame_done, 1);
    check("t6_cont_busy", busy, 1);

    beat(1'b1, 1'b0);
    for (int i = 0; i < 260; i++) begin
      beat(1'b0, 1'b0);
      beat(1'b1, 1'b0);
    end
    check("t6_err_sat", err_cnt, 255);
    check("t6_no_frame", symbol_cnt, 0);
    stop = 1'b1;
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    check("t6_stop_busy", busy, 0);
    check("t6_stop_init", sys_init, 1);
    check("t6_stop_no_pulse", {frame_done, sync_lost}, 0);
    tick();
    check("t6_stop_prio", busy, 0);
    start_acq();
    check("t6_err_clr", err_cnt, 0);
    check("t6_restart_busy", busy, 1);
    check("fd_total", fd_cnt, 4);
    check("sl_total", sl_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
